// File: rtl/posit_encoder_if.sv
// Field-form request and packed-word response of the posit encoder.
// master drives the decoded fields, slave (the encoder) returns posit_num/done/busy.
interface posit_encoder_if;
  logic              start;
  logic              sign;
  logic signed [5:0] k;
  logic [2:0]        exp_value;
  logic [31:0]       mantissa;
  logic              ZERO;
  logic              NAR;
  logic [31:0]       posit_num;
  logic              done;
  logic              busy;

  modport master (
    output start, sign, k, exp_value, mantissa, ZERO, NAR,
    input  posit_num, done, busy
  );

  modport slave (
    input  start, sign, k, exp_value, mantissa, ZERO, NAR,
    output posit_num, done, busy
  );
endinterface

// File: rtl/posit_encoder.sv
// Multi-cycle posit<32,3> encoder: packs sign/regime/exponent/fraction into a word.
// Define POSIT_ENC_ROUND_EN for round-to-nearest-even; otherwise dropped bits truncate.
//
// state  | meaning
// IDLE   | waiting for start; ZERO/NAR resolved here directly
// REGIME | shift one regime bit (run or terminator) per cycle into body
// EXP    | append the exponent bits that still fit
// FRAC   | fill the remaining body bits from the fraction
// ROUND  | register posit_num (rounded when enabled), raise done
// FINISH | done high for exactly this cycle
module posit_encoder (
  input  logic           clk,
  input  logic           rst,
  posit_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REGIME,
    S_EXP,
    S_FRAC,
    S_ROUND,
    S_FINISH
  } state_t;

  localparam logic signed [5:0] K_HI    = 6'sd30;
  localparam logic signed [5:0] K_LO_IN = -6'sd31;
  localparam logic signed [5:0] K_LO    = -6'sd30;
  localparam logic [30:0]       MAXPOS  = 31'h7FFF_FFFF;

  state_t      state;
  logic        sign_r;
  logic [2:0]  exp_r;
  logic [30:0] frac_r;
  logic        regime_bit;
  logic [4:0]  run_left;
  logic [4:0]  reg_left;
  logic [4:0]  reg_total;
  logic [30:0] body;

  logic signed [5:0] k_cl;
  logic [4:0]  run_n;
  logic [4:0]  rlen_n;
  logic        regime_out;
  logic [4:0]  avail;
  logic [1:0]  e_n;
  logic [4:0]  f_n;
  logic [30:0] body_exp;
  logic [30:0] body_frac;
  logic [30:0] body_rnd;

`ifdef POSIT_ENC_ROUND_EN
  logic        guard;
  logic        sticky;
  logic [2:0]  exp_drop;
  logic [30:0] frac_drop;
  logic        round_up;
`endif

  // Regime length from the clamped k; k in [-30,30] keeps every count within 5 bits.
  always_comb begin
    k_cl = bus.k;
    if (bus.k >= K_HI)
      k_cl = K_HI;
    else if (bus.k <= K_LO_IN)
      k_cl = K_LO;
    run_n  = k_cl[5] ? (5'd0 - k_cl[4:0]) : (k_cl[4:0] + 5'd1);
    rlen_n = (run_n == 5'd31) ? 5'd31 : (run_n + 5'd1);
  end

  always_comb begin
    regime_out = (run_left != 5'd0) ? regime_bit : ~regime_bit;
    avail      = 5'd31 - reg_total;
    e_n        = (avail >= 5'd3) ? 2'd3 : avail[1:0];
    f_n        = avail - {3'd0, e_n};
    body_exp   = (body << e_n) | {28'd0, exp_r >> (2'd3 - e_n)};
    body_frac  = (body << f_n) | (frac_r >> (5'd31 - f_n));
  end

`ifdef POSIT_ENC_ROUND_EN
  // Body is never zero after packing, so only the saturation case needs guarding.
  always_comb begin
    exp_drop  = exp_r << e_n;
    frac_drop = frac_r << f_n;
    round_up  = guard & (sticky | body[0]) & (body != MAXPOS);
    body_rnd  = body + {30'd0, round_up};
  end
`else
  always_comb begin
    body_rnd = body;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.posit_num <= 32'd0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      sign_r        <= 1'b0;
      exp_r         <= 3'd0;
      frac_r        <= 31'd0;
      regime_bit    <= 1'b0;
      run_left      <= 5'd0;
      reg_left      <= 5'd0;
      reg_total     <= 5'd0;
      body          <= 31'd0;
`ifdef POSIT_ENC_ROUND_EN
      guard         <= 1'b0;
      sticky        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.NAR) begin
              bus.posit_num <= 32'h8000_0000;
              bus.done      <= 1'b1;
              state         <= S_FINISH;
            end else if (bus.ZERO) begin
              bus.posit_num <= 32'd0;
              bus.done      <= 1'b1;
              state         <= S_FINISH;
            end else begin
              sign_r     <= bus.sign;
              exp_r      <= bus.exp_value;
              frac_r     <= bus.mantissa[30:0];
              regime_bit <= ~k_cl[5];
              run_left   <= run_n;
              reg_left   <= rlen_n;
              reg_total  <= rlen_n;
              body       <= 31'd0;
`ifdef POSIT_ENC_ROUND_EN
              guard      <= 1'b0;
              sticky     <= 1'b0;
`endif
              state      <= S_REGIME;
            end
          end
        end

        S_REGIME: begin
          body     <= {body[29:0], regime_out};
          reg_left <= reg_left - 5'd1;
          if (run_left != 5'd0)
            run_left <= run_left - 5'd1;
          if (reg_left == 5'd1)
            state <= S_EXP;
        end

        S_EXP: begin
          body <= body_exp;
`ifdef POSIT_ENC_ROUND_EN
          // Exponent truncated: its leftover bits lead, the whole fraction is sticky.
          if (e_n != 2'd3) begin
            guard  <= exp_drop[2];
            sticky <= (|exp_drop[1:0]) | (|frac_r);
          end
`endif
          state <= S_FRAC;
        end

        S_FRAC: begin
          body <= body_frac;
`ifdef POSIT_ENC_ROUND_EN
          if (e_n == 2'd3) begin
            guard  <= frac_drop[30];
            sticky <= |frac_drop[29:0];
          end
`endif
          state <= S_ROUND;
        end

        S_ROUND: begin
          bus.posit_num <= {sign_r, body_rnd};
          bus.done      <= 1'b1;
          state         <= S_FINISH;
        end

        S_FINISH: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Scoreboard bench for posit_encoder: directed field vectors plus decode->encode loopback.
module tb_posit_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_encoder_if bus ();

  posit_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h required=no_done", bus.posit_num);
      end else begin
        cur = sb.pop_front();
        check({cur.name, "_word"}, bus.posit_num, cur.val);
        check({cur.name, "_latency"}, 32'(cyc), 32'(cur.due));
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic signed [5:0] kk, input logic [2:0] e,
                       input logic [31:0] m, input logic z, input logic n);
    bus.sign      = s;
    bus.k         = kk;
    bus.exp_value = e;
    bus.mantissa  = m;
    bus.ZERO      = z;
    bus.NAR       = n;
  endtask

  // poke > 0: after that many cycles, pulse start with NAR set while the encode is running.
  task automatic issue(input string name, input logic s, input logic signed [5:0] kk,
                       input logic [2:0] e, input logic [31:0] m, input logic z, input logic n,
                       input logic [31:0] expv, input int lat, input int poke);
    @(negedge clk);
    drive(s, kk, e, m, z, n);
    bus.start = 1'b1;
    sb.push_back('{name, expv, cyc + 1 + lat});
    @(negedge clk);
    bus.start = 1'b0;
    drive(~s, ~kk, ~e, ~m, z, n);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
      drive(1'b1, 6'sd0, 3'd0, 32'd0, 1'b0, 1'b1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.NAR   = 1'b0;
    end
    wait_done(name);
  endtask

  function automatic void decode(input logic [31:0] w, output logic s, output logic signed [5:0] kk,
                                 output logic [2:0] e, output logic [31:0] m, output logic z,
                                 output logic n);
    logic [30:0] b;
    logic [30:0] rem;
    logic        first;
    logic        run;
    int          cnt;
    int          used;
    b     = w[30:0];
    first = b[30];
    run   = 1'b1;
    cnt   = 0;
    for (int i = 30; i >= 0; i--) begin
      if (run && b[i] == first) cnt++;
      else run = 1'b0;
    end
    kk   = first ? 6'(cnt - 1) : 6'(-cnt);
    used = (cnt < 31) ? cnt + 1 : 31;
    rem  = b << used;
    s    = w[31];
    e    = rem[30:28];
    m    = {1'b1, rem[27:0], 3'b000};
    z    = (w == 32'd0);
    n    = (w == 32'h8000_0000);
  endfunction

  logic [31:0]       w;
  logic              ls, lz, ln;
  logic signed [5:0] lk;
  logic [2:0]        le;
  logic [31:0]       lm;
  int                lr;

  initial begin
    bus.start = 1'b0;
    drive(1'b0, 6'sd0, 3'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_word", bus.posit_num, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;

    issue("k0",      1'b0, 6'sd0,   3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h4000_0000, 5, 0);
    issue("k2",      1'b0, 6'sd2,   3'd5, 32'hC000_0000, 1'b0, 1'b0, 32'h7580_0000, 7, 0);
    repeat (3) @(negedge clk);
    check("hold_word", bus.posit_num, 32'h7580_0000);
    issue("k2_neg",  1'b1, 6'sd2,   3'd5, 32'hC000_0000, 1'b0, 1'b0, 32'hF580_0000, 7, 0);
    issue("km1",     1'b0, -6'sd1,  3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h2000_0000, 5, 0);
    issue("k30",     1'b0, 6'sd30,  3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 34, 0);
    issue("k31_clamp", 1'b0, 6'sd31, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 34, 0);
    issue("km31_clamp", 1'b0, -6'sd31, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0001, 34, 0);
    issue("nar_zero", 1'b0, 6'sd0,  3'd0, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0000, 0, 0);
    issue("zero_neg", 1'b1, 6'sd5,  3'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 0, 0);
    issue("busy_poke", 1'b0, 6'sd2, 3'd5, 32'hC000_0000, 1'b0, 1'b0, 32'h7580_0000, 7, 2);
    issue("k29_tie", 1'b0, 6'sd29,  3'd4, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_FFFE, 34, 0);
`ifdef POSIT_ENC_ROUND_EN
    issue("k29_up",  1'b0, 6'sd29,  3'd6, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 34, 0);
    issue("km3_rnd", 1'b0, -6'sd3,  3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h1000_0000, 7, 0);
`else
    issue("k29_up",  1'b0, 6'sd29,  3'd6, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_FFFE, 34, 0);
    issue("km3_rnd", 1'b0, -6'sd3,  3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0FFF_FFFF, 7, 0);
`endif

    // Reset in the middle of a long regime: no done may follow.
    @(negedge clk);
    drive(1'b0, 6'sd20, 3'd2, 32'h8000_0000, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_word", bus.posit_num, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    issue("after_rst", 1'b0, 6'sd0, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h4000_0000, 5, 0);

    for (int t = 0; t < 24; t++) begin
      w = $urandom();
      if (t == 0) w = 32'h7FFF_FFFF;
      if (t == 1) w = 32'h8000_0001;
      decode(w, ls, lk, le, lm, lz, ln);
      lr = (lk >= 0) ? int'(lk) + 2 : 1 - int'(lk);
      if (lr > 31) lr = 31;
      issue("loopback", ls, lk, le, lm, lz, ln, w, (lz || ln) ? 0 : lr + 3, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
